// File: rtl/iv_seq_pkg.sv
// Shared types and constants for the note step sequencer.
// Holds the state encoding, the note codes, the step entry layout and the power-on arpeggio.
package iv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam logic [1:0] NOTE_FS5 = 2'd0;
  localparam logic [1:0] NOTE_A5  = 2'd1;
  localparam logic [1:0] NOTE_CS6 = 2'd2;
  localparam logic [1:0] NOTE_E6  = 2'd3;

  typedef struct packed {
    logic       on;
    logic [1:0] note;
  } step_t;

  // Up/down arpeggio FS5 A5 CS6 E6 E6 CS6 A5 FS5, repeated for longer patterns.
  function automatic step_t default_step(input logic [3:0] idx);
    step_t s;
    s.on = 1'b1;
    case (idx[2:0])
      3'd0, 3'd7: s.note = NOTE_FS5;
      3'd1, 3'd6: s.note = NOTE_A5;
      3'd2, 3'd5: s.note = NOTE_CS6;
      default:    s.note = NOTE_E6;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/note_sequencer_timer.sv
// Per-step tick counter for the note sequencer: wraps every STEP_TICKS clocks.
// Reports expiry on the last tick and whether the next tick falls in the gate-off gap.
module seq_step_timer #(
  parameter int STEP_TICKS = 2_500_000,
  parameter int GATE_GAP   = 250_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic expire_o,
  output logic gap_nxt_o
);

  localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STEP_TICKS - 1);
  // One extra bit so an open window equal to STEP_TICKS (legato) still fits.
  localparam logic [TICK_W:0] OPEN_TICKS = (TICK_W + 1)'(STEP_TICKS - GATE_GAP);

  logic [TICK_W-1:0] tick_q, tick_d;

  assign expire_o = (tick_q == LAST_TICK);

  always_comb begin
    tick_d = tick_q;
    if (clear_i || expire_o) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  assign gap_nxt_o = !({1'b0, tick_d} < OPEN_TICKS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer feeding the square-wave oscillator's note select and the output gate.
// Holds the writable pattern RAM, the play/loop FSM and the current step registers.
module note_sequencer
  import iv_seq_pkg::*;
#(
  parameter int STEP_TICKS = 2_500_000,
  parameter int GATE_GAP   = 250_000,
  parameter int NUM_STEPS  = 8,
  localparam int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PLAY,
  input  logic             LOOP_EN,
  input  logic             WR_EN,
  input  logic [IDX_W-1:0] WR_ADDR,
  input  logic [2:0]       WR_DATA,
  output logic [1:0]       NOTE_SEL,
  output logic             GATE,
  output logic [IDX_W-1:0] STEP_IDX,
  output logic             STEP_STROBE,
  output logic             DONE
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       note_q, note_d;
  logic             on_q, on_d;
  logic             gate_q, gate_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  step_t            pat_q [NUM_STEPS];

  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic             timer_clear;
  logic             expire;
  logic             gap_nxt;

  // The timer only runs while playing; any other state parks it at tick 0.
  assign timer_clear = !(state_q == ST_RUN && PLAY);

  seq_step_timer #(
    .STEP_TICKS(STEP_TICKS),
    .GATE_GAP  (GATE_GAP)
  ) u_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clear_i  (timer_clear),
    .expire_o (expire),
    .gap_nxt_o(gap_nxt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    note_d   = note_q;
    on_d     = on_q;
    gate_d   = 1'b0;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;

    case (state_q)
      ST_IDLE: begin
        if (PLAY) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!PLAY) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (expire) begin
          if (idx_q == LAST_IDX && !LOOP_EN) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            load     = 1'b1;
            load_idx = idx_q + 1'b1;
          end
        end else begin
          gate_d = on_q && !gap_nxt;
        end
      end
      ST_DONE: begin
        if (!PLAY) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // A load reads the pattern before this cycle's write lands.
    if (load) begin
      idx_d    = load_idx;
      note_d   = pat_q[load_idx].note;
      on_d     = pat_q[load_idx].on;
      gate_d   = pat_q[load_idx].on;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      note_q   <= '0;
      on_q     <= 1'b0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        pat_q[i] <= default_step(4'(i));
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      on_q     <= on_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      if (WR_EN) begin
        pat_q[WR_ADDR] <= step_t'(WR_DATA);
      end
    end
  end

  assign NOTE_SEL    = note_q;
  assign GATE        = gate_q;
  assign STEP_IDX    = idx_q;
  assign STEP_STROBE = strobe_q;
  assign DONE        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios with literal expectations,
// then randomized play/loop/write/reset traffic compared every cycle against a behavioural model.
module tb_note_sequencer;

  localparam int ST = 10;
  localparam int GG = 2;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk, rst, play, loop_en, wr_en;
  logic [IW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic [1:0]    note_sel;
  logic          gate, step_strobe, done;
  logic [IW-1:0] step_idx;

  int checks   = 0;
  int failures = 0;

  note_sequencer #(.STEP_TICKS(ST), .GATE_GAP(GG), .NUM_STEPS(N)) dut (
    .CLK(clk), .RST(rst), .PLAY(play), .LOOP_EN(loop_en),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .NOTE_SEL(note_sel), .GATE(gate), .STEP_IDX(step_idx),
    .STEP_STROBE(step_strobe), .DONE(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks clocks elapsed since the run started; step boundaries
  // are multiples of ST, and gate is open for the first ST-GG clocks of each step.
  int         arp [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  logic [2:0] m_pat [N];
  logic [2:0] rd [N];
  int         m_mode;  // 0 idle, 1 running, 2 finished
  int         m_el;
  int         m_idx;
  logic [1:0] m_note;
  logic       m_on, m_gate, m_strobe, m_done;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 0; m_el = 0; m_idx = 0;
      m_note = 2'd0; m_on = 1'b0; m_gate = 1'b0; m_strobe = 1'b0; m_done = 1'b0;
      for (int i = 0; i < N; i++) m_pat[i] = {1'b1, 2'(arp[i % 8])};
    end else if (m_valid) begin
      rd = m_pat;
      m_strobe = 1'b0;
      case (m_mode)
        0: if (play) begin
          m_mode = 1; m_el = 0; m_idx = 0;
          m_note = rd[0][1:0]; m_on = rd[0][2]; m_gate = m_on; m_strobe = 1'b1;
        end
        1: if (!play) begin
          m_mode = 0; m_idx = 0; m_gate = 1'b0;
        end else begin
          m_el++;
          if (m_el % ST == 0) begin
            if (m_idx == N - 1 && !loop_en) begin
              m_mode = 2; m_gate = 1'b0; m_done = 1'b1;
            end else begin
              m_idx = (m_idx + 1) % N;
              m_note = rd[m_idx][1:0]; m_on = rd[m_idx][2];
              m_gate = m_on; m_strobe = 1'b1;
            end
          end else begin
            m_gate = m_on && ((m_el % ST) < ST - GG);
          end
        end
        default: if (!play) begin
          m_mode = 0; m_idx = 0; m_done = 1'b0;
        end
      endcase
      if (wr_en) m_pat[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_note", 8'(note_sel), 8'(m_note));
      chk("model_gate", 8'(gate), 8'(m_gate));
      chk("model_idx", 8'(step_idx), 8'(m_idx));
      chk("model_strobe", 8'(step_strobe), 8'(m_strobe));
      chk("model_done", 8'(done), 8'(m_done));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; loop_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wait_n(3);
    rst = 1'b0;
    chk("rst_note", 8'(note_sel), 8'd0);
    chk("rst_gate", 8'(gate), 8'd0);
    chk("rst_idx", 8'(step_idx), 8'd0);
    chk("rst_strobe", 8'(step_strobe), 8'd0);
    chk("rst_done", 8'(done), 8'd0);

    // Looping run: strobes every ST clocks, arpeggio 0,1,2,3 then wrap.
    play = 1'b1; loop_en = 1'b1;
    wait_n(1);
    chk("s1_first_strobe", 8'(step_strobe), 8'd1);
    chk("s1_first_note", 8'(note_sel), 8'd0);
    chk("s1_first_gate", 8'(gate), 8'd1);
    wait_n(7);
    chk("s1_gate_tick7", 8'(gate), 8'd1);
    wait_n(1);
    chk("s1_gate_tick8", 8'(gate), 8'd0);
    chk("s1_no_strobe", 8'(step_strobe), 8'd0);
    wait_n(2);
    chk("s1_step1_strobe", 8'(step_strobe), 8'd1);
    chk("s1_step1_note", 8'(note_sel), 8'd1);
    chk("s1_step1_idx", 8'(step_idx), 8'd1);
    wait_n(30);
    chk("s1_wrap_strobe", 8'(step_strobe), 8'd1);
    chk("s1_wrap_idx", 8'(step_idx), 8'd0);
    chk("s1_wrap_note", 8'(note_sel), 8'd0);
    play = 1'b0;
    wait_n(1);
    chk("s1_stop_gate", 8'(gate), 8'd0);

    // One-shot run ends in DONE and holds until PLAY drops.
    loop_en = 1'b0; play = 1'b1;
    wait_n(41);
    chk("s2_done", 8'(done), 8'd1);
    chk("s2_done_gate", 8'(gate), 8'd0);
    chk("s2_done_note", 8'(note_sel), 8'd3);
    chk("s2_done_idx", 8'(step_idx), 8'd3);
    chk("s2_done_strobe", 8'(step_strobe), 8'd0);
    wait_n(5);
    chk("s2_done_held", 8'(done), 8'd1);
    play = 1'b0;
    wait_n(1);
    chk("s2_idle_done", 8'(done), 8'd0);
    play = 1'b1;
    wait_n(1);
    chk("s2_restart_strobe", 8'(step_strobe), 8'd1);
    chk("s2_restart_idx", 8'(step_idx), 8'd0);
    play = 1'b0;
    wait_n(2);

    // Rest written into step 1 before playing.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 3'b010;
    wait_n(1);
    wr_en = 1'b0; loop_en = 1'b1; play = 1'b1;
    wait_n(11);
    chk("s3_rest_note", 8'(note_sel), 8'd2);
    chk("s3_rest_gate", 8'(gate), 8'd0);
    wait_n(5);
    chk("s3_rest_gate_mid", 8'(gate), 8'd0);
    play = 1'b0;
    wait_n(2);

    // PLAY dropped at tick 4 of step 2.
    play = 1'b1;
    wait_n(25);
    chk("s5_idx_before", 8'(step_idx), 8'd2);
    play = 1'b0;
    wait_n(1);
    chk("s5_gate", 8'(gate), 8'd0);
    chk("s5_idx", 8'(step_idx), 8'd0);
    chk("s5_note_held", 8'(note_sel), 8'd2);
    chk("s5_no_strobe", 8'(step_strobe), 8'd0);
    play = 1'b1;
    wait_n(1);
    chk("s5_restart_strobe", 8'(step_strobe), 8'd1);
    chk("s5_restart_note", 8'(note_sel), 8'd0);

    // Write to step 2 on the very cycle it loads: old data plays first.
    wait_n(19);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 3'b100;
    wait_n(1);
    wr_en = 1'b0;
    chk("s4_load_idx", 8'(step_idx), 8'd2);
    chk("s4_old_note", 8'(note_sel), 8'd2);
    chk("s4_load_strobe", 8'(step_strobe), 8'd1);
    wait_n(40);
    chk("s4_next_idx", 8'(step_idx), 8'd2);
    chk("s4_new_note", 8'(note_sel), 8'd0);
    chk("s4_new_gate", 8'(gate), 8'd1);

    // Reset mid step 3 restores the default pattern.
    wait_n(13);
    rst = 1'b1;
    wait_n(1);
    chk("s6_rst_note", 8'(note_sel), 8'd0);
    chk("s6_rst_idx", 8'(step_idx), 8'd0);
    chk("s6_rst_gate", 8'(gate), 8'd0);
    rst = 1'b0; play = 1'b0;
    wait_n(1);
    play = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_n(s == 0 ? 1 : ST);
      chk("s6_note", 8'(note_sel), 8'(s));
      chk("s6_gate", 8'(gate), 8'd1);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) play = ~play;
      loop_en = ($urandom_range(0, 3) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = IW'($urandom_range(0, N - 1));
      wr_data = 3'($urandom_range(0, 7));
      rst     = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; wr_en = 1'b0;
    wait_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
